// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture/generator pair.
package pwm_capture_pkg;
    localparam int PWM_VALUE_W = 10;
    localparam int T_LSB_W     = 12;
    localparam int DUTY_W      = PWM_VALUE_W + 1;

    // One above the largest reportable duty, so overflow stays visible.
    localparam logic [DUTY_W-1:0] DUTY_MAX = 11'd1024;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        LOST    = 2'd2
    } cap_state_e;

    // A zero LSB width would never wrap the prescaler, so it counts as one.
    function automatic logic [T_LSB_W-1:0] eff_t_lsb(input logic [T_LSB_W-1:0] t);
        return (t == '0) ? T_LSB_W'(1) : t;
    endfunction
endpackage

// File: rtl/pwm_capture_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    // Shift the input through STAGES flops; the last one is the clean copy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= (sr << 1) | STAGES'(d);
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/pwm_capture.sv
// Measures PWM duty per sync frame in units of t_lsb clock cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_signal,
    input  logic                   pwm_in,
    input  logic [T_LSB_W-1:0]     t_lsb,
    output logic [PWM_VALUE_W-1:0] pwm_value,
    output logic                   value_valid,
    output logic                   saturated,
    output logic                   timeout
);
    logic               pwm_s, sync_s, sync_prev, sync_edge;
    cap_state_e         state;
    logic [T_LSB_W-1:0] t_lat, t_eff, presc, presc_nxt;
    logic [DUTY_W-1:0]  duty, duty_nxt;
    logic [23:0]        wd, wd_nxt;
    logic               wrap;

    // Equal-depth synchronizers keep pwm and sync samples cycle-aligned.
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_pwm (
        .clk(clk), .reset_n(reset_n), .d(pwm_in), .q(pwm_s)
    );
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_frame (
        .clk(clk), .reset_n(reset_n), .d(sync_signal), .q(sync_s)
    );

    assign sync_edge = sync_s & ~sync_prev;

    // Next-count values including this cycle's sample, so a wrap that lands
    // on the closing sync edge is still credited to the closing period.
    always_comb begin
        t_eff     = eff_t_lsb(t_lat);
        wrap      = pwm_s && (presc == t_eff - T_LSB_W'(1));
        presc_nxt = presc;
        duty_nxt  = duty;
        if (pwm_s) presc_nxt = wrap ? '0 : presc + T_LSB_W'(1);
        if (wrap && duty != DUTY_MAX) duty_nxt = duty + DUTY_W'(1);
        wd_nxt    = wd + 24'd1;
    end

    // Control FSM with counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARM;
            sync_prev   <= 1'b0;
            t_lat       <= '0;
            presc       <= '0;
            duty        <= '0;
            wd          <= '0;
            pwm_value   <= '0;
            value_valid <= 1'b0;
            saturated   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            sync_prev   <= sync_s;
            value_valid <= 1'b0;
            case (state)
                ARM, LOST: begin
                    // Partial period before the first edge is never reported.
                    if (sync_edge) begin
                        presc   <= '0;
                        duty    <= '0;
                        wd      <= '0;
                        t_lat   <= t_lsb;
                        timeout <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (sync_edge) begin
                        pwm_value   <= duty_nxt[DUTY_W-1] ? {PWM_VALUE_W{1'b1}}
                                                          : duty_nxt[PWM_VALUE_W-1:0];
                        saturated   <= duty_nxt[DUTY_W-1];
                        value_valid <= 1'b1;
                        presc       <= '0;
                        duty        <= '0;
                        wd          <= '0;
                        t_lat       <= t_lsb;
                    end else if (wd_nxt == TIMEOUT_CYCLES) begin
                        timeout <= 1'b1;
                        state   <= LOST;
                    end else begin
                        presc <= presc_nxt;
                        duty  <= duty_nxt;
                        wd    <= wd_nxt;
                    end
                end
                default: state <= ARM;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus randomized
// periods checked against an arithmetic duty model.
module tb_pwm_capture;
    logic        clk = 1'b0, reset_n = 1'b0, sync_signal = 1'b0, pwm_in = 1'b0;
    logic [11:0] t_lsb = 12'd4;
    logic [9:0]  pwm_value, to_value;
    logic        value_valid, saturated, timeout;
    logic        to_valid, to_sat, to_timeout;

    int tests = 0, fails = 0, cyc = 0, last_sync_cyc = 0, dbl_err = 0, vcnt_to = 0;
    bit prev_valid = 1'b0;

    typedef struct { int v; int s; int lat; } ent_t;
    ent_t vq[$];

    pwm_capture dut (
        .clk(clk), .reset_n(reset_n), .sync_signal(sync_signal), .pwm_in(pwm_in),
        .t_lsb(t_lsb), .pwm_value(pwm_value), .value_valid(value_valid),
        .saturated(saturated), .timeout(timeout)
    );

    pwm_capture #(.TIMEOUT_CYCLES(24'd1000)) dut_to (
        .clk(clk), .reset_n(reset_n), .sync_signal(sync_signal), .pwm_in(pwm_in),
        .t_lsb(t_lsb), .pwm_value(to_value), .value_valid(to_valid),
        .saturated(to_sat), .timeout(to_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each value_valid pulse of the main instance and flag pulses
    // longer than one cycle.
    always @(negedge clk) begin
        if (value_valid) vq.push_back('{v: int'(pwm_value), s: int'(saturated), lat: cyc - last_sync_cyc});
        if (value_valid && prev_valid) dbl_err++;
        prev_valid = value_valid;
        if (to_valid) vcnt_to++;
    end

    // Duty in LSBs from high-cycle count, clamped at 1024.
    function automatic int model_duty(input int high, input int t);
        int d;
        d = high / ((t == 0) ? 1 : t);
        if (d > 1024) d = 1024;
        return d;
    endfunction

    function automatic ent_t pop_ent();
        ent_t e;
        if (vq.size() > 0) e = vq.pop_front();
        else e = '{v: -1, s: -1, lat: -1};
        return e;
    endfunction

    // One frame: sync high 8 cycles from index 0, pwm high at indices 1..high;
    // psync drives pwm at index 0, which belongs to the previous period.
    task automatic drive_period(input int len, input int high, input bit psync = 1'b0,
                                input int tchg_at = -1, input int tchg_val = 0);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0) last_sync_cyc = cyc;
            sync_signal = (i < 8);
            pwm_in      = (i == 0) ? psync : (i <= high);
            if (i == tchg_at) t_lsb = 12'(tchg_val);
        end
    endtask

    task automatic test_reset();
        #12;
        tests++; if (pwm_value !== 10'd0) begin fails++; $display("FAIL reset_value got=%0d exp=0", pwm_value); end
        tests++; if (value_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", value_valid); end
        tests++; if (saturated !== 1'b0) begin fails++; $display("FAIL reset_sat got=%0b exp=0", saturated); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        @(posedge clk); #1 reset_n = 1'b1;
        t_lsb = 12'd4;
        drive_period(20, 0);
        tests++; if (vq.size() !== 0) begin fails++; $display("FAIL reset_arm_no_valid got=%0d exp=0", vq.size()); end
        drive_period(20, 0);
        tests++; if (vq.size() !== 1) begin fails++; $display("FAIL reset_first_meas count got=%0d exp=1", vq.size()); end
        vq.delete();
    endtask

    task automatic test_basic();
        ent_t e;
        t_lsb = 12'd4;
        drive_period(5000, 400);
        vq.delete();
        drive_period(20, 0);
        tests++; if (vq.size() !== 1) begin fails++; $display("FAIL basic_count got=%0d exp=1", vq.size()); end
        e = pop_ent();
        tests++; if (e.v !== 100) begin fails++; $display("FAIL basic_value got=%0d exp=100", e.v); end
        tests++; if (e.s !== 0) begin fails++; $display("FAIL basic_sat got=%0d exp=0", e.s); end
        tests++; if (e.lat !== 3) begin fails++; $display("FAIL basic_latency got=%0d exp=3", e.lat); end
        tests++; if (dbl_err !== 0) begin fails++; $display("FAIL basic_pulse_width long_pulses=%0d exp=0", dbl_err); end
    endtask

    task automatic test_saturate();
        ent_t e;
        t_lsb = 12'd4;
        drive_period(4200, 4100);
        vq.delete();
        drive_period(500, 100);
        e = pop_ent();
        tests++; if (e.v !== 1023) begin fails++; $display("FAIL sat_value got=%0d exp=1023", e.v); end
        tests++; if (e.s !== 1) begin fails++; $display("FAIL sat_flag got=%0d exp=1", e.s); end
        drive_period(20, 0);
        e = pop_ent();
        tests++; if (e.v !== 25) begin fails++; $display("FAIL sat_recover_value got=%0d exp=25", e.v); end
        tests++; if (e.s !== 0) begin fails++; $display("FAIL sat_recover_flag got=%0d exp=0", e.s); end
    endtask

    task automatic test_truncation();
        ent_t e;
        t_lsb = 12'd0;
        drive_period(100, 37);
        vq.delete();
        t_lsb = 12'd5;
        drive_period(100, 14);
        e = pop_ent();
        tests++; if (e.v !== 37) begin fails++; $display("FAIL tlsb_zero got=%0d exp=37", e.v); end
        t_lsb = 12'd4;
        drive_period(100, 7);
        e = pop_ent();
        tests++; if (e.v !== 2) begin fails++; $display("FAIL truncation got=%0d exp=2", e.v); end
        drive_period(20, 0, 1'b1);
        e = pop_ent();
        tests++; if (e.v !== 2) begin fails++; $display("FAIL wrap_on_edge got=%0d exp=2", e.v); end
    endtask

    task automatic test_tlsb_change();
        ent_t e;
        t_lsb = 12'd4;
        drive_period(1000, 400, 1'b0, 500, 8);
        vq.delete();
        drive_period(1000, 400);
        e = pop_ent();
        tests++; if (e.v !== 100) begin fails++; $display("FAIL tchg_same_period got=%0d exp=100", e.v); end
        drive_period(20, 0);
        e = pop_ent();
        tests++; if (e.v !== 50) begin fails++; $display("FAIL tchg_next_period got=%0d exp=50", e.v); end
    endtask

    task automatic test_midreset();
        ent_t e;
        t_lsb = 12'd4;
        drive_period(1000, 400);
        vq.delete();
        drive_period(205, 200);
        e = pop_ent();
        tests++; if (e.v !== 100) begin fails++; $display("FAIL midrst_before got=%0d exp=100", e.v); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (pwm_value !== 10'd0) begin fails++; $display("FAIL midrst_value got=%0d exp=0", pwm_value); end
        tests++; if ({value_valid, saturated, timeout} !== 3'b000) begin fails++; $display("FAIL midrst_flags got=%b exp=000", {value_valid, saturated, timeout}); end
        @(posedge clk); #1;
        @(posedge clk); #1 reset_n = 1'b1;
        drive_period(1000, 400);
        tests++; if (vq.size() !== 0) begin fails++; $display("FAIL midrst_no_valid got=%0d exp=0", vq.size()); end
        drive_period(20, 0);
        e = pop_ent();
        tests++; if (e.v !== 100) begin fails++; $display("FAIL midrst_after got=%0d exp=100", e.v); end
    endtask

    task automatic test_timeout();
        int n0, p;
        t_lsb = 12'd4;
        drive_period(300, 40);
        n0 = vcnt_to;
        drive_period(300, 40);
        p = last_sync_cyc;
        tests++; if (vcnt_to !== n0 + 1) begin fails++; $display("FAIL to_pre_count got=%0d exp=%0d", vcnt_to, n0 + 1); end
        tests++; if (to_value !== 10'd10) begin fails++; $display("FAIL to_pre_value got=%0d exp=10", to_value); end
        pwm_in = 1'b1;
        while (cyc < p + 1002) begin @(posedge clk); #1; end
        @(negedge clk);
        tests++; if (to_timeout !== 1'b0) begin fails++; $display("FAIL to_early got=%0b exp=0", to_timeout); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (to_timeout !== 1'b1) begin fails++; $display("FAIL to_set got=%0b exp=1", to_timeout); end
        repeat (50) @(posedge clk);
        #1;
        tests++; if (to_value !== 10'd10) begin fails++; $display("FAIL to_hold got=%0d exp=10", to_value); end
        n0 = vcnt_to;
        drive_period(300, 80);
        tests++; if (to_timeout !== 1'b0) begin fails++; $display("FAIL to_clear got=%0b exp=0", to_timeout); end
        tests++; if (vcnt_to !== n0) begin fails++; $display("FAIL to_rearm_no_valid got=%0d exp=%0d", vcnt_to, n0); end
        drive_period(300, 0);
        tests++; if (vcnt_to !== n0 + 1) begin fails++; $display("FAIL to_resume_count got=%0d exp=%0d", vcnt_to, n0 + 1); end
        tests++; if (to_value !== 10'd20) begin fails++; $display("FAIL to_resume_value got=%0d exp=20", to_value); end
    endtask

    task automatic test_random();
        ent_t e;
        int t_prev, h_prev, nt, len, h, d, ev, es;
        bit ps;
        t_prev = $urandom_range(15, 0);
        t_lsb  = 12'(t_prev);
        len    = $urandom_range(1500, 20);
        h_prev = $urandom_range(len - 1, 0);
        drive_period(len, h_prev);
        vq.delete();
        for (int k = 0; k < 20; k++) begin
            nt  = $urandom_range(15, 0);
            len = $urandom_range(1500, 20);
            h   = $urandom_range(len - 1, 0);
            ps  = 1'($urandom_range(1, 0));
            t_lsb = 12'(nt);
            drive_period(len, h, ps);
            d  = model_duty(h_prev + int'(ps), t_prev);
            ev = (d > 1023) ? 1023 : d;
            es = (d > 1023) ? 1 : 0;
            e  = pop_ent();
            tests++; if (e.v !== ev || e.s !== es) begin
                fails++; $display("FAIL rand_%0d got=%0d/%0d exp=%0d/%0d (high=%0d t=%0d)", k, e.v, e.s, ev, es, h_prev + int'(ps), t_prev);
            end
            tests++; if (e.lat !== 3) begin fails++; $display("FAIL rand_lat_%0d got=%0d exp=3", k, e.lat); end
            t_prev = nt;
            h_prev = h;
        end
        tests++; if (dbl_err !== 0) begin fails++; $display("FAIL rand_pulse_width long_pulses=%0d exp=0", dbl_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_truncation();
        test_tlsb_change();
        test_midreset();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
